dafx_frame_router: RTL

Parametrised successor to the fixed two-channel ADC capture and IRQ logic of the DAFX core. Deframes an N-slot TDM sample stream from the audio ADC, merges it with M sign-extended oscillator outputs into one channel vector for `mixer_top`, and emits the frame strobe. Adds frame-alignment checking with resync and error counting, plus NR_OF_IRQ_P programmable sticky IRQ timers clocked by either `clk` or frames.

---
 rtl/dafx_pkg.sv | 17 +
 rtl/dafx_irq_timer.sv | 61 ++++++
 rtl/dafx_frame_router.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dafx_pkg.sv
// dafx_pkg: shared constants and types for the DAFX frame router slice.
//   NR_OF_*_C      default channel / timer counts
//   IRQ_CNT_WIDTH_C timer counter and period width
//   frame_state_t  deframer FSM state
package dafx_pkg;

  localparam int NR_OF_ADC_CH_C  = 2;
  localparam int NR_OF_OSC_C     = 1;
  localparam int NR_OF_IRQ_C     = 2;
  localparam int IRQ_CNT_WIDTH_C = 32;

  typedef enum logic {
    RESYNC  = 1'b0,
    COLLECT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/dafx_irq_timer.sv
// dafx_irq_timer: one programmable sticky IRQ timer.
//   period_i    terminal count (0 disables and holds the counter at 0)
//   mode_i      0 = tick every clk, 1 = tick on fs_strobe_i
//   fs_strobe_i frame strobe from the deframer
//   clear_i     pulse clears the pending flag (a same-cycle set wins)
//   irq_o       sticky pending flag
module dafx_irq_timer
  import dafx_pkg::*;
#(
  parameter int CNT_W = IRQ_CNT_WIDTH_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period_i,
  input  logic             mode_i,
  input  logic             fs_strobe_i,
  input  logic             clear_i,
  output logic             irq_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q;
  logic             pend_q, pend_d;
  logic             tick, hit;

  always_comb begin
    tick  = mode_i ? fs_strobe_i : 1'b1;
    hit   = 1'b0;
    cnt_d = cnt_q;
    if (period_i == '0) begin
      cnt_d = '0;
    end else if (mode_i != mode_q) begin
      // Switching tick source restarts the count from zero.
      cnt_d = '0;
    end else if (tick) begin
      // >= so that a period lowered below the running count fires next tick.
      if (cnt_q >= period_i - 1'b1) begin
        cnt_d = '0;
        hit   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pend_d = hit | (pend_q & ~clear_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_i;
      pend_q <= pend_d;
    end
  end

  assign irq_o = pend_q;

endmodule

// File: rtl/dafx_frame_router.sv
// dafx_frame_router: deframes an N-slot TDM ADC stream, merges it with M
// sign-extended oscillator samples into channel_data, emits fs_strobe per
// committed frame, counts framing errors and runs NR_OF_IRQ_P IRQ timers.
//   adc_data/adc_valid/adc_ready/adc_last  ADC slot stream
//   osc_data                               oscillator samples, sampled on commit
//   channel_data                           [0..N-1] ADC slots, [N..] oscillators
//   fs_strobe                              one-cycle pulse per committed frame
//   cr_irq_period/cr_irq_mode/cmd_clear_irq/irq  timer control and sticky IRQs
//   cmd_clear_errors/sr_frame_error_count  saturating framing-error counter
module dafx_frame_router
  import dafx_pkg::*;
#(
  parameter  int AUDIO_WIDTH_P    = 24,
  parameter  int OSC_WIDTH_P      = 24,
  parameter  int NR_OF_ADC_CH_P   = NR_OF_ADC_CH_C,
  parameter  int NR_OF_OSC_P      = NR_OF_OSC_C,
  parameter  int NR_OF_IRQ_P      = NR_OF_IRQ_C,
  parameter  int IRQ_CNT_WIDTH_P  = IRQ_CNT_WIDTH_C,
  localparam int NR_OF_CHANNELS_P = NR_OF_ADC_CH_P + NR_OF_OSC_P,
  // Keeps osc_data legal when there are no oscillators.
  localparam int OSC_ARR_P        = (NR_OF_OSC_P > 0) ? NR_OF_OSC_P : 1
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [AUDIO_WIDTH_P-1:0]                           adc_data,
  input  logic                                               adc_valid,
  output logic                                               adc_ready,
  input  logic                                               adc_last,
  input  logic [OSC_ARR_P-1:0][OSC_WIDTH_P-1:0]              osc_data,
  output logic [NR_OF_CHANNELS_P-1:0][AUDIO_WIDTH_P-1:0]     channel_data,
  output logic                                               fs_strobe,
  input  logic [NR_OF_IRQ_P-1:0][IRQ_CNT_WIDTH_P-1:0]        cr_irq_period,
  input  logic [NR_OF_IRQ_P-1:0]                             cr_irq_mode,
  input  logic [NR_OF_IRQ_P-1:0]                             cmd_clear_irq,
  output logic [NR_OF_IRQ_P-1:0]                             irq,
  input  logic                                               cmd_clear_errors,
  output logic [15:0]                                        sr_frame_error_count
);

  localparam int SLOT_W = (NR_OF_ADC_CH_P > 1) ? $clog2(NR_OF_ADC_CH_P) : 1;
  localparam int SHD_N  = (NR_OF_ADC_CH_P > 1) ? NR_OF_ADC_CH_P - 1 : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NR_OF_ADC_CH_P - 1);

  frame_state_t                                  state_q, state_d;
  logic [SLOT_W-1:0]                             slot_q, slot_d;
  logic [SHD_N-1:0][AUDIO_WIDTH_P-1:0]           shadow_q, shadow_d;
  logic [NR_OF_CHANNELS_P-1:0][AUDIO_WIDTH_P-1:0] chan_q, chan_d;
  logic                                          ready_q, strobe_q, strobe_d;
  logic [15:0]                                   err_q, err_d;
  logic                                          err_ev, accept;

  assign accept = adc_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    chan_d   = chan_q;
    strobe_d = 1'b0;
    err_ev   = 1'b0;
    if (accept) begin
      unique case (state_q)
        // Discard until a frame boundary so a partial frame is never committed.
        RESYNC: if (adc_last) begin
          state_d = COLLECT;
          slot_d  = '0;
        end
        COLLECT: begin
          if (slot_q != LAST_SLOT) begin
            if (adc_last) begin
              // Short frame: boundary is known, so stay aligned.
              err_ev = 1'b1;
              slot_d = '0;
            end else begin
              shadow_d[slot_q] = adc_data;
              slot_d           = slot_q + 1'b1;
            end
          end else if (adc_last) begin
            for (int k = 0; k < NR_OF_ADC_CH_P - 1; k++) chan_d[k] = shadow_q[k];
            chan_d[NR_OF_ADC_CH_P-1] = adc_data;
            for (int j = 0; j < NR_OF_OSC_P; j++)
              chan_d[NR_OF_ADC_CH_P+j] = AUDIO_WIDTH_P'($signed(osc_data[j]));
            strobe_d = 1'b1;
            slot_d   = '0;
          end else begin
            // Long frame: boundary lost, hunt for the next last.
            err_ev  = 1'b1;
            slot_d  = '0;
            state_d = RESYNC;
          end
        end
        default: state_d = RESYNC;
      endcase
    end

    if (cmd_clear_errors)                  err_d = {15'd0, err_ev};
    else if (err_ev && err_q != 16'hFFFF)  err_d = err_q + 16'd1;
    else                                   err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESYNC;
      slot_q   <= '0;
      shadow_q <= '0;
      chan_q   <= '0;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      chan_q   <= chan_d;
      ready_q  <= 1'b1;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign adc_ready            = ready_q;
  assign channel_data         = chan_q;
  assign fs_strobe            = strobe_q;
  assign sr_frame_error_count = err_q;

  for (genvar i = 0; i < NR_OF_IRQ_P; i++) begin : g_irq
    dafx_irq_timer #(
      .CNT_W(IRQ_CNT_WIDTH_P)
    ) u_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .period_i   (cr_irq_period[i]),
      .mode_i     (cr_irq_mode[i]),
      .fs_strobe_i(strobe_q),
      .clear_i    (cmd_clear_irq[i]),
      .irq_o      (irq[i])
    );
  end

endmodule
